mips32_mc_core: RTL and testbench

Parametrised multi-cycle MIPS32 core executing a 16-instruction subset plus HALT, fetching through a variable-latency request/response instruction port. Contains register file, data memory and control FSM; exposes the last written result for the top-level. Adds the team's dual-write instruction ADDPS, which writes two registers in one cycle.

---
 rtl/mips32_pkg.sv | 54 +++++
 rtl/mips32_alu.sv | 28 ++
 rtl/mips32_mc_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips32_mc_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the multi-cycle MIPS32 core: opcode and funct
// encodings, the control FSM state type, ALU operation codes and the
// immediate-extension helpers.
package mips32_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_ADDPS = 6'h3F;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU for the multi-cycle core. The zero flag reports
// an all-zero result and is used with ALU_SUB for beq/bne comparisons.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero
);

  // Result selection by operation; slt compares as signed two's complement
  always_comb begin
    y = 32'h0000_0000;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = 32'h0000_0000;
    endcase
    zero = (y == 32'h0000_0000);
  end

endmodule

// File: rtl/mips32_mc_core.sv
// Multi-cycle MIPS32 subset core. Instructions are fetched over a
// request/response port with arbitrary latency, then walk through
// DECODE, EXEC and optionally MEM/WB. The register file has two write
// ports so ADDPS can update rd and rd+1 in the same writeback cycle.
module mips32_mc_core
  import mips32_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int DADDR_W = 16,
  parameter int PC_W    = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     result,
  output logic            result_valid,
  output logic [31:0]     retired,
  output logic            halted
);

  localparam int RA_W = $clog2(NREG);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       alu_out;
  logic [31:0]       alu_out2;
  logic [RA_W-1:0]   wb_dest;
  logic              wb_dual;

  logic [31:0]       regs [NREG];
  logic [31:0]       dmem [2**DADDR_W];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [RA_W-1:0]   rs_idx;
  logic [RA_W-1:0]   rt_idx;
  logic [RA_W-1:0]   rd_idx;
  logic [RA_W-1:0]   wb_dest2;
  logic [31:0]       simm;
  logic [31:0]       zimm;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   j_target;
  logic [DADDR_W-1:0] dmem_idx;
  logic              funct_known;
  logic              br_taken;

  alu_op_t           alu_op;
  logic [31:0]       alu_b;
  logic [31:0]       alu_y;
  logic              alu_zero;

  // Register fields wrap modulo NREG by keeping only the low index bits
  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign rs_idx    = ir[21 +: RA_W];
  assign rt_idx    = ir[16 +: RA_W];
  assign rd_idx    = ir[11 +: RA_W];
  assign wb_dest2  = wb_dest + {{(RA_W-1){1'b0}}, 1'b1};
  assign simm      = sext16(ir[15:0]);
  assign zimm      = zext16(ir[15:0]);
  assign pc_plus4  = pc + PC_W'(3'd4);
  assign br_target = pc_plus4 + PC_W'({simm[29:0], 2'b00});
  assign j_target  = PC_W'({ir[25:0], 2'b00});
  assign dmem_idx  = alu_out[2 +: DADDR_W];
  assign imem_addr = pc;
  assign funct_known = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_ADDPS};
  assign br_taken  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;

  // ALU operation and second operand chosen from the latched instruction
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin alu_op = ALU_ADD; alu_b = simm; end
      OP_SLTI:         begin alu_op = ALU_SLT; alu_b = simm; end
      OP_ANDI:         begin alu_op = ALU_AND; alu_b = zimm; end
      OP_ORI:          begin alu_op = ALU_OR;  alu_b = zimm; end
      OP_BEQ, OP_BNE:  begin alu_op = ALU_SUB; alu_b = b;    end
      default:         begin alu_op = ALU_ADD; alu_b = b;    end
    endcase
  end

  mips32_alu u_alu (
    .a    (a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Data memory store port; memory contents survive reset, so no reset here
  always_ff @(posedge clk) begin
    if (state == ST_MEM && opcode == OP_SW) begin
      dmem[dmem_idx] <= b;
    end
  end

  // Control FSM with register file, fetch handshake and retirement counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FETCH;
      pc           <= '0;
      ir           <= 32'h0000_0000;
      a            <= 32'h0000_0000;
      b            <= 32'h0000_0000;
      alu_out      <= 32'h0000_0000;
      alu_out2     <= 32'h0000_0000;
      wb_dest      <= '0;
      wb_dual      <= 1'b0;
      imem_req     <= 1'b0;
      result       <= 32'h0000_0000;
      result_valid <= 1'b0;
      retired      <= 32'h0000_0000;
      halted       <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          // First FETCH after reset raises the request; later entries arrive with it already set
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_rvalid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a     <= regs[rs_idx];
          b     <= regs[rt_idx];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              wb_dest  <= rd_idx;
              alu_out  <= alu_y;
              alu_out2 <= a - b;
              wb_dual  <= (funct == FN_ADDPS);
              if (funct_known) begin
                state <= ST_WB;
              end else begin
                pc       <= pc_plus4;
                retired  <= retired + 32'd1;
                imem_req <= 1'b1;
                state    <= ST_FETCH;
              end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
              wb_dest <= rt_idx;
              alu_out <= alu_y;
              wb_dual <= 1'b0;
              state   <= ST_WB;
            end
            OP_LW, OP_SW: begin
              wb_dest <= rt_idx;
              alu_out <= alu_y;
              wb_dual <= 1'b0;
              state   <= ST_MEM;
            end
            OP_BEQ, OP_BNE: begin
              pc       <= br_taken ? br_target : pc_plus4;
              retired  <= retired + 32'd1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            OP_J: begin
              pc       <= j_target;
              retired  <= retired + 32'd1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            OP_HALT: begin
              pc      <= pc_plus4;
              retired <= retired + 32'd1;
              halted  <= 1'b1;
              state   <= ST_HALTED;
            end
            default: begin
              // Unknown opcode retires as a NOP
              pc       <= pc_plus4;
              retired  <= retired + 32'd1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (opcode == OP_LW) begin
            alu_out <= dmem[dmem_idx];
            state   <= ST_WB;
          end else begin
            pc       <= pc_plus4;
            retired  <= retired + 32'd1;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_WB: begin
          // Register 0 stays zero; the pulse still reports the computed value
          if (wb_dest != {RA_W{1'b0}}) begin
            regs[wb_dest] <= alu_out;
          end
          if (wb_dual && (wb_dest2 != {RA_W{1'b0}})) begin
            regs[wb_dest2] <= alu_out2;
          end
          result       <= alu_out;
          result_valid <= 1'b1;
          pc           <= pc_plus4;
          retired      <= retired + 32'd1;
          imem_req     <= 1'b1;
          state        <= ST_FETCH;
        end
        ST_HALTED: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mc_core.sv
// Scoreboard bench for mips32_mc_core: a program trace table supplies the
// expected fetch addresses, inter-fetch cycle gaps and writeback results;
// independent monitors pop and compare them as the core presents fetches
// and result pulses.
module tb_mips32_mc_core;

  localparam int PC_W = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = 32'h0;
  logic [31:0]     result;
  logic            result_valid;
  logic [31:0]     retired;
  logic            halted;

  mips32_mc_core #(.NREG(32), .DADDR_W(16), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .result       (result),
    .result_valid (result_valid),
    .retired      (retired),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          has_res;
    logic [31:0] res;
    int          cpi;
  } step_t;

  typedef struct {
    logic [31:0] addr;
    int          gap;
  } fetch_t;

  step_t       trace[$];
  logic [31:0] prog [0:255];
  logic [31:0] exp_res[$];
  fetch_t      exp_fetch[$];

  int errors = 0;
  int checks = 0;
  int delay = 0;
  bit stray = 1'b0;
  bit fetch_first = 1'b1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic add(input logic [31:0] pc, input logic [31:0] instr, input bit has, input logic [31:0] res, input int cpi);
    step_t s;
    s.pc = pc; s.instr = instr; s.has_res = has; s.res = res; s.cpi = cpi;
    trace.push_back(s);
    prog[pc[9:2]] = instr;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] instr);
    prog[pc[9:2]] = instr;
  endtask

  // Instruction memory responder: answers after 'delay' request cycles, optional stray rvalid while idle
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!imem_req) begin
        cnt = 0; imem_rvalid = stray; imem_rdata = 32'hFC00_0000;
      end else if (cnt >= delay) begin
        imem_rvalid = 1'b1; imem_rdata = prog[imem_addr[9:2]]; cnt++;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = 32'hFC00_0000; cnt++;
      end
    end
  end

  // Fetch monitor: address and cycle gap of every accepted fetch
  initial begin
    int cyc;
    int last;
    fetch_t f;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && imem_req && imem_rvalid) begin
        if (exp_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr 0x%05h, expected no fetch", imem_addr);
        end else begin
          f = exp_fetch.pop_front();
          check32("fetch_addr", 32'(imem_addr), f.addr);
          if (!fetch_first) check32("fetch_gap", 32'(cyc - last), 32'(f.gap));
          fetch_first = 1'b0;
          last = cyc;
        end
      end
    end
  end

  // Result monitor: every result_valid pulse consumes one expected value
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got 0x%08h, expected no pulse", result);
        end else begin
          check32("result", result, exp_res.pop_front());
        end
      end
    end
  end

  task automatic start_run(input int d, input bit s);
    fetch_t f;
    delay = d; stray = s; fetch_first = 1'b1;
    exp_res.delete(); exp_fetch.delete();
    foreach (trace[i]) begin
      f.addr = trace[i].pc;
      f.gap  = (i == 0) ? -1 : trace[i-1].cpi + d;
      exp_fetch.push_back(f);
      if (trace[i].has_res) exp_res.push_back(trace[i].res);
    end
  endtask

  task automatic finish_run();
    int n;
    n = 0;
    while (!halted && n < 4000) begin @(negedge clk); n++; end
    check32("halted", 32'(halted), 32'd1);
    repeat (12) @(negedge clk);
    check32("imem_req_after_halt", 32'(imem_req), 32'd0);
    check32("retired", retired, 32'(trace.size()));
    check32("last_result", result, 32'h0000_1234);
    check32("results_left", 32'(exp_res.size()), 32'd0);
    check32("fetches_left", 32'(exp_fetch.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check32({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check32({tag, "_result"}, result, 32'd0);
    check32({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check32({tag, "_retired"}, retired, 32'd0);
    check32({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    add(32'h000, itype(6'h08, 1, 0, 16'd5),        1'b1, 32'h0000_0005, 4);
    add(32'h004, itype(6'h08, 2, 0, 16'hFFFD),     1'b1, 32'hFFFF_FFFD, 4);
    add(32'h008, rtype(3, 1, 2, 6'h20),            1'b1, 32'h0000_0002, 4);
    add(32'h00C, itype(6'h08, 1, 0, 16'd7),        1'b1, 32'h0000_0007, 4);
    add(32'h010, itype(6'h04, 0, 0, 16'd2),        1'b0, 32'h0, 3);   // beq taken -> 0x1C
    put(32'h014, itype(6'h08, 9, 0, 16'd99));
    put(32'h018, itype(6'h08, 9, 0, 16'd98));
    add(32'h01C, itype(6'h08, 2, 0, 16'd3),        1'b1, 32'h0000_0003, 4);
    add(32'h020, rtype(4, 1, 2, 6'h3F),            1'b1, 32'h0000_000A, 4);   // addps: $4=10, $5=4
    add(32'h024, rtype(7, 5, 0, 6'h20),            1'b1, 32'h0000_0004, 4);
    add(32'h028, itype(6'h05, 1, 1, 16'd5),        1'b0, 32'h0, 3);   // bne not taken
    add(32'h02C, itype(6'h08, 1, 0, 16'h1234),     1'b1, 32'h0000_1234, 4);
    add(32'h030, itype(6'h2B, 1, 0, 16'd8),        1'b0, 32'h0, 4);   // sw $1,8($0)
    add(32'h034, itype(6'h23, 6, 0, 16'd8),        1'b1, 32'h0000_1234, 5);
    add(32'h038, rtype(31, 1, 2, 6'h3F),           1'b1, 32'h0000_1237, 4);   // second write wraps to $0
    add(32'h03C, rtype(8, 0, 0, 6'h25),            1'b1, 32'h0000_0000, 4);
    add(32'h040, {6'h02, 26'h40},                  1'b0, 32'h0, 3);   // j -> 0x100
    put(32'h044, itype(6'h08, 9, 0, 16'd97));
    add(32'h100, rtype(10, 31, 1, 6'h22),          1'b1, 32'h0000_0003, 4);
    add(32'h104, itype(6'h08, 13, 0, 16'hFFFF),    1'b1, 32'hFFFF_FFFF, 4);
    add(32'h108, rtype(12, 13, 0, 6'h2A),          1'b1, 32'h0000_0001, 4);
    add(32'h10C, itype(6'h0A, 11, 0, 16'hFFFF),    1'b1, 32'h0000_0000, 4);
    add(32'h110, itype(6'h0D, 14, 0, 16'hF0F0),    1'b1, 32'h0000_F0F0, 4);
    add(32'h114, itype(6'h0C, 15, 13, 16'h8001),   1'b1, 32'h0000_8001, 4);
    add(32'h118, rtype(16, 15, 1, 6'h26),          1'b1, 32'h0000_9235, 4);
    add(32'h11C, rtype(17, 13, 1, 6'h24),          1'b1, 32'h0000_1234, 4);
    add(32'h120, rtype(18, 15, 2, 6'h25),          1'b1, 32'h0000_8003, 4);
    add(32'h124, rtype(19, 1, 1, 6'h01),           1'b0, 32'h0, 3);   // unknown funct
    add(32'h128, itype(6'h3E, 19, 1, 16'd5),       1'b0, 32'h0, 3);   // unknown opcode
    add(32'h12C, rtype(21, 19, 0, 6'h20),          1'b1, 32'h0000_0000, 4);
    add(32'h130, itype(6'h23, 22, 0, 16'd11),      1'b1, 32'h0000_1234, 5);   // low address bits ignored
    add(32'h134, 32'hFC00_0000,                    1'b0, 32'h0, 0);   // HALT

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    start_run(0, 1'b0);
    rst_n = 1'b1;
    finish_run();

    rst_n = 1'b0; repeat (3) @(negedge clk);
    start_run(1, 1'b0);
    rst_n = 1'b1;
    finish_run();

    rst_n = 1'b0; repeat (3) @(negedge clk);
    start_run(7, 1'b1);
    rst_n = 1'b1;
    finish_run();

    // Abort a run in the middle of a slow fetch, then restart from pc 0
    rst_n = 1'b0; repeat (3) @(negedge clk);
    start_run(7, 1'b0);
    rst_n = 1'b1;
    n = 0;
    while (!(retired >= 32'd5 && imem_req) && n < 1000) begin @(negedge clk); n++; end
    check32("abort_point", 32'(retired >= 32'd5 && imem_req), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midfetch");
    exp_res.delete(); exp_fetch.delete();
    stray = 1'b1;
    repeat (3) @(negedge clk);
    start_run(0, 1'b1);
    rst_n = 1'b1;
    finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
